// File: rtl/control_unit_fsm_pkg.sv
// Shared definitions for the cs147sec05 control unit: state codes, opcode and
// funct constants, ALU operation codes, CTRL bit positions and a per-instruction
// data-path settings record with helpers that build its common shapes.
package control_unit_fsm_pkg;

  localparam int CTRL_WIDTH     = 32;
  localparam int ALU_OPRN_WIDTH = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXE    = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_MULI  = 6'h1d;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h2c;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  // ALU operation codes
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_ADD = 6'd1;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_SUB = 6'd2;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_MUL = 6'd3;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_SHR = 6'd4;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_SHL = 6'd5;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_AND = 6'd6;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OR  = 6'd7;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_NOR = 6'd8;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_SLT = 6'd9;

  // CTRL bit positions; bits above CB_PC_LOAD are always zero
  localparam int CB_PC_LOAD  = 28;
  localparam int CB_SP_LOAD  = 27;
  localparam int CB_PC_SEL_1 = 26;
  localparam int CB_PC_SEL_2 = 25;
  localparam int CB_PC_SEL_3 = 24;
  localparam int CB_R1_SEL_1 = 23;
  localparam int CB_IR_LOAD  = 22;
  localparam int CB_WA_SEL_1 = 21;
  localparam int CB_WA_SEL_2 = 20;
  localparam int CB_WA_SEL_3 = 19;
  localparam int CB_WD_SEL_1 = 18;
  localparam int CB_WD_SEL_2 = 17;
  localparam int CB_WD_SEL_3 = 16;
  localparam int CB_OP1_SEL_1 = 15;
  localparam int CB_OP2_SEL_1 = 14;
  localparam int CB_OP2_SEL_2 = 13;
  localparam int CB_OP2_SEL_3 = 12;
  localparam int CB_OP2_SEL_4 = 11;
  localparam int CB_REG_R    = 10;
  localparam int CB_REG_W    = 9;
  localparam int CB_ALU_MSB  = 8;
  localparam int CB_ALU_LSB  = 3;
  localparam int CB_MA_SEL_1 = 2;
  localparam int CB_MA_SEL_2 = 1;
  localparam int CB_MD_SEL_1 = 0;

  // Everything one instruction needs from the data path, independent of state
  typedef struct packed {
    logic                      r1_sel_1;
    logic                      op1_sel_1;
    logic                      op2_sel_1;
    logic                      op2_sel_2;
    logic                      op2_sel_3;
    logic                      op2_sel_4;
    logic [ALU_OPRN_WIDTH-1:0] alu_oprn;
    logic                      reg_w;
    logic                      sp_load;
    logic                      wa_sel_1;
    logic                      wa_sel_2;
    logic                      wa_sel_3;
    logic                      wd_sel_1;
    logic                      wd_sel_2;
    logic                      wd_sel_3;
    logic                      pc_sel_1;
    logic                      pc_sel_3;
    logic                      br_eq;
    logic                      br_ne;
    logic                      mem_read;
    logic                      mem_write;
    logic                      ma_sel_1;
    logic                      md_sel_1;
  } inst_info_t;

  // No-op: next PC is pc+1, nothing written, no memory access
  function automatic inst_info_t info_nop();
    inst_info_t i;
    i = {$bits(inst_info_t){1'b0}};
    i.pc_sel_1 = 1'b1;
    i.pc_sel_3 = 1'b1;
    return i;
  endfunction

  // Register-register ALU op writing rd
  function automatic inst_info_t info_rtype(input logic [ALU_OPRN_WIDTH-1:0] alu);
    inst_info_t i;
    i = info_nop();
    i.op2_sel_4 = 1'b1;
    i.alu_oprn  = alu;
    i.reg_w     = 1'b1;
    i.wa_sel_3  = 1'b1;
    i.wd_sel_3  = 1'b1;
    return i;
  endfunction

  // Register-immediate ALU op writing rt; sext picks sign- over zero-extension
  function automatic inst_info_t info_imm(input logic [ALU_OPRN_WIDTH-1:0] alu,
                                          input logic sext);
    inst_info_t i;
    i = info_nop();
    i.op2_sel_2 = sext;
    i.alu_oprn  = alu;
    i.reg_w     = 1'b1;
    i.wa_sel_1  = 1'b1;
    i.wa_sel_3  = 1'b1;
    i.wd_sel_3  = 1'b1;
    return i;
  endfunction

endpackage

// File: rtl/control_unit_fsm_ctrl_decode.sv
// Combinational map from (state, opcode, funct, zero_q) to the CTRL word and
// the memory strobes. Operand/ALU selects appear in EXE and are held through
// MEM and WB; write-back and PC selects are only driven in WB.
module control_unit_fsm_ctrl_decode
  import control_unit_fsm_pkg::*;
(
  input  state_e                state,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero_q,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic                  read,
  output logic                  write
);

  inst_info_t info_s;

  // Operand-side fields shared by EXE, MEM and WB
  function automatic logic [CTRL_WIDTH-1:0] operand_bits(input inst_info_t i);
    logic [CTRL_WIDTH-1:0] w;
    w = {CTRL_WIDTH{1'b0}};
    w[CB_R1_SEL_1]  = i.r1_sel_1;
    w[CB_OP1_SEL_1] = i.op1_sel_1;
    w[CB_OP2_SEL_1] = i.op2_sel_1;
    w[CB_OP2_SEL_2] = i.op2_sel_2;
    w[CB_OP2_SEL_3] = i.op2_sel_3;
    w[CB_OP2_SEL_4] = i.op2_sel_4;
    w[CB_ALU_MSB:CB_ALU_LSB] = i.alu_oprn;
    return w;
  endfunction

  // Classify the instruction into the data-path settings it needs
  always_comb begin
    info_s = info_nop();
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: info_s = info_rtype(ALU_ADD);
          FN_SUB: info_s = info_rtype(ALU_SUB);
          FN_MUL: info_s = info_rtype(ALU_MUL);
          FN_AND: info_s = info_rtype(ALU_AND);
          FN_OR:  info_s = info_rtype(ALU_OR);
          FN_NOR: info_s = info_rtype(ALU_NOR);
          FN_SLT: info_s = info_rtype(ALU_SLT);
          FN_SLL: begin
            info_s = info_rtype(ALU_SHL);
            info_s.op2_sel_4 = 1'b0;
            info_s.op2_sel_3 = 1'b1;
            info_s.op2_sel_1 = 1'b1;
          end
          FN_SRL: begin
            info_s = info_rtype(ALU_SHR);
            info_s.op2_sel_4 = 1'b0;
            info_s.op2_sel_3 = 1'b1;
            info_s.op2_sel_1 = 1'b1;
          end
          FN_JR:   info_s.pc_sel_1 = 1'b0;
          default: info_s = info_nop();
        endcase
      end
      OP_ADDI: info_s = info_imm(ALU_ADD, 1'b1);
      OP_MULI: info_s = info_imm(ALU_MUL, 1'b1);
      OP_SLTI: info_s = info_imm(ALU_SLT, 1'b1);
      OP_ANDI: info_s = info_imm(ALU_AND, 1'b0);
      OP_ORI:  info_s = info_imm(ALU_OR, 1'b0);
      OP_LUI: begin
        info_s.reg_w    = 1'b1;
        info_s.wa_sel_1 = 1'b1;
        info_s.wa_sel_3 = 1'b1;
        info_s.wd_sel_2 = 1'b1;
        info_s.wd_sel_3 = 1'b1;
      end
      OP_BEQ: begin
        info_s.op2_sel_4 = 1'b1;
        info_s.alu_oprn  = ALU_SUB;
        info_s.br_eq     = 1'b1;
      end
      OP_BNE: begin
        info_s.op2_sel_4 = 1'b1;
        info_s.alu_oprn  = ALU_SUB;
        info_s.br_ne     = 1'b1;
      end
      OP_LW: begin
        info_s = info_imm(ALU_ADD, 1'b1);
        info_s.wd_sel_1 = 1'b1;
        info_s.mem_read = 1'b1;
      end
      OP_SW: begin
        info_s.op2_sel_2 = 1'b1;
        info_s.alu_oprn  = ALU_ADD;
        info_s.mem_write = 1'b1;
      end
      OP_JMP: info_s.pc_sel_3 = 1'b0;
      OP_JAL: begin
        info_s.pc_sel_3 = 1'b0;
        info_s.reg_w    = 1'b1;
        info_s.wa_sel_2 = 1'b1;
      end
      OP_PUSH: begin
        // r0 is routed through r1 so it can be stored at sp, then sp-1
        info_s.r1_sel_1  = 1'b1;
        info_s.op1_sel_1 = 1'b1;
        info_s.op2_sel_3 = 1'b1;
        info_s.alu_oprn  = ALU_SUB;
        info_s.sp_load   = 1'b1;
        info_s.mem_write = 1'b1;
        info_s.ma_sel_1  = 1'b1;
        info_s.md_sel_1  = 1'b1;
      end
      OP_POP: begin
        // Read from sp+1 into r0 and move sp to sp+1
        info_s.op1_sel_1 = 1'b1;
        info_s.op2_sel_3 = 1'b1;
        info_s.alu_oprn  = ALU_ADD;
        info_s.sp_load   = 1'b1;
        info_s.reg_w     = 1'b1;
        info_s.wd_sel_1  = 1'b1;
        info_s.wd_sel_3  = 1'b1;
        info_s.mem_read  = 1'b1;
      end
      default: info_s = info_nop();
    endcase
  end

  // Assemble CTRL and the memory strobes for the current state
  always_comb begin
    ctrl  = {CTRL_WIDTH{1'b0}};
    read  = 1'b0;
    write = 1'b0;
    case (state)
      S_IDLE: begin
        ctrl = {CTRL_WIDTH{1'b0}};
      end
      S_FETCH: begin
        // IR is still stale here, so nothing depends on the instruction
        read = 1'b1;
        ctrl[CB_MA_SEL_2] = 1'b1;
        ctrl[CB_IR_LOAD]  = 1'b1;
      end
      S_DECODE: begin
        ctrl[CB_REG_R]    = 1'b1;
        ctrl[CB_R1_SEL_1] = info_s.r1_sel_1;
      end
      S_EXE: begin
        ctrl = operand_bits(info_s);
        ctrl[CB_REG_R] = 1'b1;
      end
      S_MEM: begin
        ctrl = operand_bits(info_s);
        ctrl[CB_REG_R]    = 1'b1;
        ctrl[CB_MA_SEL_1] = info_s.ma_sel_1;
        ctrl[CB_MD_SEL_1] = info_s.md_sel_1;
        read  = info_s.mem_read;
        write = info_s.mem_write;
      end
      S_WB: begin
        ctrl = operand_bits(info_s);
        ctrl[CB_PC_LOAD]  = 1'b1;
        ctrl[CB_SP_LOAD]  = info_s.sp_load;
        ctrl[CB_REG_W]    = info_s.reg_w;
        ctrl[CB_PC_SEL_1] = info_s.pc_sel_1;
        ctrl[CB_PC_SEL_2] = (info_s.br_eq & zero_q) | (info_s.br_ne & ~zero_q);
        ctrl[CB_PC_SEL_3] = info_s.pc_sel_3;
        ctrl[CB_WA_SEL_1] = info_s.wa_sel_1;
        ctrl[CB_WA_SEL_2] = info_s.wa_sel_2;
        ctrl[CB_WA_SEL_3] = info_s.wa_sel_3;
        ctrl[CB_WD_SEL_1] = info_s.wd_sel_1;
        ctrl[CB_WD_SEL_2] = info_s.wd_sel_2;
        ctrl[CB_WD_SEL_3] = info_s.wd_sel_3;
      end
      default: begin
        ctrl = {CTRL_WIDTH{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/control_unit_fsm.sv
// Multicycle sequencer for the cs147sec05 data path. Steps every instruction
// through FETCH, DECODE, EXE, MEM, WB and captures the ALU zero flag at the end
// of EXE for the branch decision in WB.
module control_unit_fsm
  import control_unit_fsm_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           INSTRUCTION,
  input  logic                  ZERO,
  output logic [CTRL_WIDTH-1:0] CTRL,
  output logic                  READ,
  output logic                  WRITE,
  output logic [2:0]            STATE
);

  state_e state_r;
  state_e next_state_s;
  logic   zero_q_r;
  logic   unused_instr_s;

  // Register, address and immediate fields are consumed by the data path only
  assign unused_instr_s = ^INSTRUCTION[25:6];
  assign STATE = state_r;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Fixed five-step sequence; illegal codes recover into FETCH
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_IDLE:   next_state_s = S_FETCH;
      S_FETCH:  next_state_s = S_DECODE;
      S_DECODE: next_state_s = S_EXE;
      S_EXE:    next_state_s = S_MEM;
      S_MEM:    next_state_s = S_WB;
      S_WB:     next_state_s = S_FETCH;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Capture the zero flag produced by the EXE-stage ALU operation
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      zero_q_r <= 1'b0;
    end else if (state_r == S_EXE) begin
      zero_q_r <= ZERO;
    end else begin
      zero_q_r <= zero_q_r;
    end
  end

  control_unit_fsm_ctrl_decode u_ctrl_decode (
    .state  (state_r),
    .opcode (INSTRUCTION[31:26]),
    .funct  (INSTRUCTION[5:0]),
    .zero_q (zero_q_r),
    .ctrl   (CTRL),
    .read   (READ),
    .write  (WRITE)
  );

endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: each step pushes the expected outputs
// into a scoreboard and pops them when the DUT reaches that state.
module tb_control_unit_fsm;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic [31:0] CTRL;
  logic        READ;
  logic        WRITE;
  logic [2:0]  STATE;

  control_unit_fsm dut (
    .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
    .CTRL(CTRL), .READ(READ), .WRITE(WRITE), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  // CTRL bit values
  localparam logic [31:0] K_PC_LOAD = 32'd1 << 28;
  localparam logic [31:0] K_SP_LOAD = 32'd1 << 27;
  localparam logic [31:0] K_PC_SEL1 = 32'd1 << 26;
  localparam logic [31:0] K_PC_SEL2 = 32'd1 << 25;
  localparam logic [31:0] K_PC_SEL3 = 32'd1 << 24;
  localparam logic [31:0] K_R1_SEL1 = 32'd1 << 23;
  localparam logic [31:0] K_IR_LOAD = 32'd1 << 22;
  localparam logic [31:0] K_WA1     = 32'd1 << 21;
  localparam logic [31:0] K_WA2     = 32'd1 << 20;
  localparam logic [31:0] K_WA3     = 32'd1 << 19;
  localparam logic [31:0] K_WD1     = 32'd1 << 18;
  localparam logic [31:0] K_WD2     = 32'd1 << 17;
  localparam logic [31:0] K_WD3     = 32'd1 << 16;
  localparam logic [31:0] K_OP1     = 32'd1 << 15;
  localparam logic [31:0] K_OP2_1   = 32'd1 << 14;
  localparam logic [31:0] K_OP2_2   = 32'd1 << 13;
  localparam logic [31:0] K_OP2_3   = 32'd1 << 12;
  localparam logic [31:0] K_OP2_4   = 32'd1 << 11;
  localparam logic [31:0] K_REG_R   = 32'd1 << 10;
  localparam logic [31:0] K_REG_W   = 32'd1 << 9;
  localparam logic [31:0] K_MA1     = 32'd1 << 2;
  localparam logic [31:0] K_MA2     = 32'd1 << 1;
  localparam logic [31:0] K_MD1     = 32'd1 << 0;

  localparam logic [31:0] PC1   = K_PC_LOAD | K_PC_SEL1 | K_PC_SEL3;
  localparam logic [31:0] PCSEL = K_PC_SEL1 | K_PC_SEL2 | K_PC_SEL3;
  localparam logic [31:0] WAWD  = K_WA1 | K_WA2 | K_WA3 | K_WD1 | K_WD2 | K_WD3;
  localparam logic [31:0] MAMD  = K_MA1 | K_MA2 | K_MD1;

  // Fields checked per state (write-back/PC selects are don't-care before WB)
  localparam logic [31:0] M_ALL    = 32'hFFFF_FFFF;
  localparam logic [31:0] M_EXE    = ~(PCSEL | WAWD | MAMD);
  localparam logic [31:0] M_MEM    = ~(PCSEL | WAWD | K_REG_R);
  localparam logic [31:0] M_MEM_NM = M_MEM & ~MAMD;
  localparam logic [31:0] M_MEM_RD = M_MEM & ~K_MD1;
  localparam logic [31:0] M_WB     = ~(K_REG_R | MAMD);

  localparam logic [31:0] FETCH_W = K_IR_LOAD | K_MA2;

  function automatic logic [31:0] alu_f(input logic [5:0] a);
    return {23'd0, a, 3'd0};
  endfunction

  typedef struct {
    string       tag;
    logic [2:0]  state;
    logic [31:0] ctrl;
    logic [31:0] mask;
    logic        rd;
    logic        wr;
  } exp_t;

  exp_t sb_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic expect_out(input string tag, input logic [2:0] st, input logic [31:0] c,
                            input logic [31:0] m, input logic rd, input logic wr);
    exp_t e;
    e.tag = tag; e.state = st; e.ctrl = c; e.mask = m; e.rd = rd; e.wr = wr;
    sb_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL scoreboard_underflow observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      tests_run++;
      assert (STATE === e.state) else begin
        tests_failed++;
        $error("FAIL %s.state observed=%0d expected=%0d", e.tag, STATE, e.state);
      end
      tests_run++;
      assert ((CTRL & e.mask) === (e.ctrl & e.mask)) else begin
        tests_failed++;
        $error("FAIL %s.ctrl observed=%08h expected=%08h mask=%08h", e.tag, CTRL, e.ctrl, e.mask);
      end
      tests_run++;
      assert (READ === e.rd) else begin
        tests_failed++;
        $error("FAIL %s.read observed=%b expected=%b", e.tag, READ, e.rd);
      end
      tests_run++;
      assert (WRITE === e.wr) else begin
        tests_failed++;
        $error("FAIL %s.write observed=%b expected=%b", e.tag, WRITE, e.wr);
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    check_now();
  endtask

  // One full instruction; z is the ZERO value presented while EXE ends
  task automatic run_instr(input string tag, input logic [31:0] instr, input logic z,
                           input logic [31:0] dec, input logic [31:0] exe,
                           input logic [31:0] mem_extra, input logic [31:0] mem_mask,
                           input logic mrd, input logic mwr, input logic [31:0] wb);
    expect_out({tag, "_fetch"}, 3'd1, FETCH_W, M_ALL, 1'b1, 1'b0);
    expect_out({tag, "_decode"}, 3'd2, dec, M_ALL, 1'b0, 1'b0);
    expect_out({tag, "_exe"}, 3'd3, exe, M_EXE, 1'b0, 1'b0);
    expect_out({tag, "_mem"}, 3'd4, exe | mem_extra, mem_mask, mrd, mwr);
    expect_out({tag, "_wb"}, 3'd5, wb, M_WB, 1'b0, 1'b0);
    ZERO = ~z;
    step();
    INSTRUCTION = instr;
    step();
    step();
    ZERO = z;
    step();
    ZERO = ~z;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b0;
    INSTRUCTION = 32'h0000_0000;
    ZERO = 1'b0;
    #12;
    expect_out("reset_idle", 3'd0, 32'd0, M_ALL, 1'b0, 1'b0);
    check_now();
    expect_out("reset_hold", 3'd0, 32'd0, M_ALL, 1'b0, 1'b0);
    step();
    RST = 1'b1;

    // add interrupted by reset during EXE
    expect_out("pre_fetch", 3'd1, FETCH_W, M_ALL, 1'b1, 1'b0);
    step();
    INSTRUCTION = 32'h0022_1820;
    expect_out("pre_decode", 3'd2, K_REG_R, M_ALL, 1'b0, 1'b0);
    step();
    expect_out("pre_exe", 3'd3, K_REG_R | K_OP2_4 | alu_f(6'd1), M_EXE, 1'b0, 1'b0);
    step();
    #2;
    RST = 1'b0;
    #1;
    expect_out("rst_mid_exe", 3'd0, 32'd0, M_ALL, 1'b0, 1'b0);
    check_now();
    expect_out("rst_held", 3'd0, 32'd0, M_ALL, 1'b0, 1'b0);
    step();
    RST = 1'b1;

    run_instr("add", 32'h0022_1820, 1'b0, K_REG_R, K_REG_R | K_OP2_4 | alu_f(6'd1),
              32'd0, M_MEM_NM, 1'b0, 1'b0,
              PC1 | K_OP2_4 | alu_f(6'd1) | K_REG_W | K_WA3 | K_WD3);
    run_instr("beq_z1", 32'h1022_0004, 1'b1, K_REG_R, K_REG_R | K_OP2_4 | alu_f(6'd2),
              32'd0, M_MEM_NM, 1'b0, 1'b0,
              PC1 | K_PC_SEL2 | K_OP2_4 | alu_f(6'd2));
    run_instr("beq_z0", 32'h1022_0004, 1'b0, K_REG_R, K_REG_R | K_OP2_4 | alu_f(6'd2),
              32'd0, M_MEM_NM, 1'b0, 1'b0,
              PC1 | K_OP2_4 | alu_f(6'd2));
    run_instr("bne_z0", 32'h1422_0004, 1'b0, K_REG_R, K_REG_R | K_OP2_4 | alu_f(6'd2),
              32'd0, M_MEM_NM, 1'b0, 1'b0,
              PC1 | K_PC_SEL2 | K_OP2_4 | alu_f(6'd2));
    run_instr("lw", 32'h8C22_0004, 1'b0, K_REG_R, K_REG_R | K_OP2_2 | alu_f(6'd1),
              32'd0, M_MEM_RD, 1'b1, 1'b0,
              PC1 | K_OP2_2 | alu_f(6'd1) | K_REG_W | K_WA3 | K_WA1 | K_WD3 | K_WD1);
    run_instr("sw", 32'hAC22_0004, 1'b0, K_REG_R, K_REG_R | K_OP2_2 | alu_f(6'd1),
              32'd0, M_MEM, 1'b0, 1'b1,
              PC1 | K_OP2_2 | alu_f(6'd1));
    run_instr("push", 32'h6C00_0000, 1'b0, K_REG_R | K_R1_SEL1,
              K_REG_R | K_R1_SEL1 | K_OP1 | K_OP2_3 | alu_f(6'd2),
              K_MA1 | K_MD1, M_MEM, 1'b0, 1'b1,
              PC1 | K_SP_LOAD | K_R1_SEL1 | K_OP1 | K_OP2_3 | alu_f(6'd2));
    run_instr("pop", 32'h7000_0000, 1'b0, K_REG_R, K_REG_R | K_OP1 | K_OP2_3 | alu_f(6'd1),
              32'd0, M_MEM_RD, 1'b1, 1'b0,
              PC1 | K_SP_LOAD | K_OP1 | K_OP2_3 | alu_f(6'd1) | K_REG_W | K_WD3 | K_WD1);
    run_instr("jal", 32'h0C00_0010, 1'b0, K_REG_R, K_REG_R,
              32'd0, M_MEM_NM, 1'b0, 1'b0,
              K_PC_LOAD | K_PC_SEL1 | K_REG_W | K_WA2);
    run_instr("nop_3f", 32'hFC00_0000, 1'b0, K_REG_R, K_REG_R,
              32'd0, M_MEM_NM, 1'b0, 1'b0, PC1);
    run_instr("sll", 32'h0002_0841, 1'b0, K_REG_R, K_REG_R | K_OP2_3 | K_OP2_1 | alu_f(6'd5),
              32'd0, M_MEM_NM, 1'b0, 1'b0,
              PC1 | K_OP2_3 | K_OP2_1 | alu_f(6'd5) | K_REG_W | K_WA3 | K_WD3);
    run_instr("jr", 32'h0020_0008, 1'b0, K_REG_R, K_REG_R,
              32'd0, M_MEM_NM, 1'b0, 1'b0, K_PC_LOAD | K_PC_SEL3);
    run_instr("andi", 32'h3022_FFFF, 1'b0, K_REG_R, K_REG_R | alu_f(6'd6),
              32'd0, M_MEM_NM, 1'b0, 1'b0,
              PC1 | alu_f(6'd6) | K_REG_W | K_WA3 | K_WA1 | K_WD3);

    tests_run++;
    assert (sb_q.size() == 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/control_unit_fsm.md
Name: control_unit_fsm

Overview:
- Multicycle sequencer that sits directly upstream of the processor data path.
- Consumes INSTRUCTION and ZERO from the data path. Produces the 32-bit CTRL word that steers every data-path mux, load enable and the ALU. Also produces the memory READ/WRITE strobes.
- Implements the cs147sec05 instruction set. Every instruction takes a fixed 5 states after IDLE: FETCH, DECODE, EXE, MEM, WB.

Parameters:
- CTRL_WIDTH, 32, width of CTRL; bits [31:29] are always 0.
- ALU_OPRN_WIDTH, 6, width of the alu_oprn field.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- INSTRUCTION  input  32  current IR contents from the data path.
- ZERO  input  1  ALU zero flag from the data path.
- CTRL  output  32  control word, packed per Behaviour.
- READ  output  1  memory read strobe.
- WRITE  output  1  memory write strobe.
- STATE  output  3  current state, for debug/verification.

Behaviour:
- CTRL[28:0] packing, MSB first:
  - pc_load, sp_load, pc_sel_1, pc_sel_2, pc_sel_3, r1_sel_1, ir_load
  - wa_sel_1..3, wd_sel_1..3, op1_sel_1, op2_sel_1..4
  - reg_r, reg_w, alu_oprn[5:0], ma_sel_1, ma_sel_2, md_sel_1
- Select polarity (0 selects the first source, 1 the second):
  - pc_sel_1: rs data / pc+1
  - pc_sel_2: mux1 / branch target
  - pc_sel_3: jump address / mux2
  - r1_sel_1: rs / r0
  - wa_sel_1: rd / rt
  - wa_sel_2: r0 / r31
  - wa_sel_3: mux2 / mux1
  - wd_sel_1: ALU / DATA_IN
  - wd_sel_2: mux1 / lui
  - wd_sel_3: pc+1 / mux2
  - op1_sel_1: r1 / sp
  - op2_sel_1: 1 / shamt
  - op2_sel_2: zero-extended / sign-extended
  - op2_sel_3: immediate / mux1
  - op2_sel_4: mux3 / r2
  - ma_sel_1: ALU / sp
  - ma_sel_2: mux1 / pc
  - md_sel_1: r2 / r1
- States: IDLE=0, FETCH=1, DECODE=2, EXE=3, MEM=4, WB=5.
  - Codes 6 and 7 are illegal and go to FETCH on the next clock.
  - Sequence: IDLE→FETCH→DECODE→EXE→MEM→WB→FETCH, one clock each, unconditional.
- Reset: RST low immediately forces IDLE, including mid-instruction. In IDLE, CTRL=0, READ=0, WRITE=0.
- Outputs are Moore-decoded from (state, INSTRUCTION, zero_q).
- FETCH:
  - READ=1, ma_sel_2=1, ir_load=1.
  - Does not depend on INSTRUCTION; IR is stale until the end of FETCH.
- DECODE: reg_r=1; r1_sel_1=1 only for push.
- EXE:
  - Per-opcode operand selects and alu_oprn are asserted; reg_r stays 1.
  - zero_q <= ZERO at the end of EXE; zero_q resets to 0.
- Select holding: select and ALU fields asserted in EXE are held unchanged through MEM and WB of the same instruction.
- MEM:
  - lw: READ=1, ma_sel_1=0.
  - pop: READ=1, address = ALU (sp+1).
  - sw: WRITE=1, md_sel_1=0.
  - push: WRITE=1, ma_sel_1=1, md_sel_1=1.
  - All other instructions: READ=0, WRITE=0.
- WB: pc_load=1 always. Default next PC is pc+1: pc_sel_1=1, pc_sel_2=0, pc_sel_3=1.
  - R-type add/sub/mul/and/or/nor/slt/sll/srl: reg_w=1, wa=rd, wd=ALU, op2=r2. sll/srl use op2=shamt instead.
  - jr: pc_sel_1=0, no reg_w.
  - addi/slti/muli: sign-extended immediate. andi/ori: zero-extended immediate. All write rt.
  - lui: wd=lui, wa=rt.
  - lw: wd=DATA_IN, wa=rt.
  - beq: pc_sel_2 = zero_q. bne: pc_sel_2 = !zero_q. Both use ALU sub of r1, r2.
  - jmp: pc_sel_3=0.
  - jal: pc_sel_3=0, reg_w=1, wa=r31, wd=pc+1.
  - push: op1=sp, op2=1, sub, sp_load=1.
  - pop: op1=sp, op2=1, add, sp_load=1, reg_w=1, wa=r0, wd=DATA_IN.
- Unknown opcode or funct: behaves as a NOP (pc+1, no reg_w, no sp_load, no memory access).
- READ and WRITE are never both 1.

Decomposition:
- Shared package (prj_definition.v) holds:
  - cs147sec05 opcode/funct constants:
    - R-type opcode 0 with funct add 0x20, sub 0x22, mul 0x2c, and 0x24, or 0x25, nor 0x27, slt 0x2a, sll 0x01, srl 0x02, jr 0x08.
    - I/J-type opcodes addi 0x08, muli 0x1d, andi 0x0c, ori 0x0d, lui 0x0f, slti 0x0a, beq 0x04, bne 0x05, lw 0x23, sw 0x2b, jmp 0x02, jal 0x03, push 0x1b, pop 0x1c.
  - ALU codes: add 1, sub 2, mul 3, shr 4, shl 5, and 6, or 7, nor 8, slt 9.
  - State codes and CTRL bit-index constants.
- One natural sub-module: ctrl_decode, a combinational map from (state, opcode, funct, zero_q) to {CTRL, READ, WRITE}. The FSM and zero_q register stay in the top module.

Test Plan:
- RST low mid-EXE of add → STATE=0, CTRL=0, READ=0 within the same cycle. Release → FETCH after 1 clock, READ=1, CTRL[22]=1 (ir_load).
- add $3,$1,$2 (0x00221820) → WB: reg_w=1, wa_sel_3=1, wa_sel_1=0, op2_sel_4=1, alu_oprn=1, pc_load=1.
- beq with ZERO=1 during EXE → WB: pc_sel_2=1. Same instruction with ZERO=0 → pc_sel_2=0.
- lw (0x8C220004) → MEM: READ=1, WRITE=0, alu_oprn=1, op2_sel_2=1. WB: wd_sel_1=1, wa_sel_1=1.
- push (0x6C000000) → MEM: WRITE=1, ma_sel_1=1, md_sel_1=1, r1_sel_1=1. WB: sp_load=1, alu_oprn=2, op1_sel_1=1.
- jal 0x0C000010 → WB: pc_sel_3=0, reg_w=1, wa_sel_3=0, wa_sel_2=1, wd_sel_3=0. Opcode 0x3F → NOP, pc+1.
